// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio output path.
//   AUDIO_IN_W    : width of demodulated audio samples
//   PWM_W         : width of the PWM generator data input
//   PWM_FRAME_LEN : PWM counter period, also the feeder's frame length
//   sat8()        : clamp a signed 16-bit value into signed 8-bit range
package audio_pkg;

   localparam int AUDIO_IN_W    = 16;
   localparam int PWM_W         = 8;
   localparam int PWM_FRAME_LEN = 256;

   function automatic logic [PWM_W-1:0] sat8(input logic signed [AUDIO_IN_W-1:0] v);
      if (v > 16'sd127)
         return 8'h7F;
      else if (v < -16'sd128)
         return 8'h80;
      else
         return v[PWM_W-1:0];
   endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst     : clock, asynchronous active-high reset
//   i_wr_en      : write request (ignored while full)
//   i_wr_data    : write data
//   i_rd_en      : read request (ignored while empty)
//   o_rd_data    : head entry, valid whenever o_empty is low
//   o_full       : no free entry
//   o_empty      : no stored entry
//   o_level      : occupancy 0..DEPTH
module audio_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_wr;
   logic             w_rd;

   assign o_full    = (r_level == FULL_LVL);
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rd_data = r_mem[r_rd_ptr];

   // A full FIFO refuses writes even when a read frees a slot this cycle.
   assign w_wr = i_wr_en && !o_full;
   assign w_rd = i_rd_en && !o_empty;

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/audio_sample_feeder.sv
// Rate adapter between the demodulator and the 8-bit PWM stage.
// Buffers 16-bit samples, pops one per PWM frame, scales by a
// power-of-two gain with saturation and holds the result for a frame.
//   clk, rst      : clock, asynchronous active-high reset
//   in_data       : signed 16-bit sample, in_valid/in_ready handshake
//   gain_shift    : right shift = 8 - gain_shift, sampled at the pop slot
//   mute          : output zero at the pop slot
//   clr_status    : clear underrun_cnt
//   data_out      : signed 8-bit sample for the PWM DataIn
//   frame_tick    : pulse on the cycle data_out updates
//   fifo_level    : FIFO occupancy
//   underrun_cnt  : saturating count of frames that found the FIFO empty
module audio_sample_feeder
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FRAME_LEN  = PWM_FRAME_LEN
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AUDIO_IN_W-1:0]         in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    gain_shift,
   input  logic                          mute,
   input  logic                          clr_status,
   output logic [PWM_W-1:0]              data_out,
   output logic                          frame_tick,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    underrun_cnt
);

   localparam int             FW   = $clog2(FRAME_LEN);
   localparam logic [FW-1:0]  LAST = FW'(FRAME_LEN - 1);

   logic [FW-1:0]                  r_fcnt;
   logic [PWM_W-1:0]               r_data_out;
   logic                           r_tick;
   logic [7:0]                     r_underrun;

   logic                           w_pop_slot;
   logic                           w_push;
   logic                           w_full;
   logic                           w_empty;
   logic [AUDIO_IN_W-1:0]          w_head;
   logic [3:0]                     w_shamt;
   logic signed [AUDIO_IN_W-1:0]   w_shifted;
   logic [PWM_W-1:0]               w_scaled;

   // Ready is held low during reset so nothing is accepted while the
   // FIFO is being cleared.
   assign in_ready   = !w_full && !rst;
   assign w_push     = in_valid && in_ready;
   assign w_pop_slot = (r_fcnt == LAST);

   audio_sync_fifo #(
      .WIDTH (AUDIO_IN_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_push),
      .i_wr_data (in_data),
      .i_rd_en   (w_pop_slot),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (fifo_level)
   );

   // gain_shift 0 keeps the top byte (shift 8); 7 gives shift 1.
   assign w_shamt   = 4'd8 - {1'b0, gain_shift};
   assign w_shifted = $signed(w_head) >>> w_shamt;
   assign w_scaled  = sat8(w_shifted);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fcnt <= '0;
      end else if (w_pop_slot) begin
         r_fcnt <= '0;
      end else begin
         r_fcnt <= r_fcnt + FW'(1);
      end
   end

   // On underrun the previous sample is held, except that mute still
   // forces silence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out <= '0;
         r_tick     <= 1'b0;
      end else begin
         r_tick <= w_pop_slot;
         if (w_pop_slot) begin
            if (mute)
               r_data_out <= '0;
            else if (!w_empty)
               r_data_out <= w_scaled;
         end
      end
   end

   // Clear takes priority over a coincident underrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underrun <= '0;
      end else if (clr_status) begin
         r_underrun <= '0;
      end else if (w_pop_slot && w_empty && (r_underrun != 8'hFF)) begin
         r_underrun <= r_underrun + 8'd1;
      end
   end

   assign data_out     = r_data_out;
   assign frame_tick   = r_tick;
   assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_audio_sample_feeder.sv
module tb_audio_sample_feeder;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  gain_shift;
   logic        mute;
   logic        clr_status;
   logic [7:0]  data_out;
   logic        frame_tick;
   logic [4:0]  fifo_level;
   logic [7:0]  underrun_cnt;

   int ecnt;
   int total;
   int passed;
   int tick_e;
   int last_e;

   audio_sample_feeder #(.FIFO_DEPTH(16), .FRAME_LEN(256)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .gain_shift   (gain_shift),
      .mute         (mute),
      .clr_status   (clr_status),
      .data_out     (data_out),
      .frame_tick   (frame_tick),
      .fifo_level   (fifo_level),
      .underrun_cnt (underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // rising edges since reset release
   always @(posedge clk or posedge rst) begin
      if (rst) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   typedef struct {
      logic [2:0]  g;
      logic        m;
      logic [15:0] d;
      logic [7:0]  e;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic wait_tick(input string nm);
      bit found;
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (frame_tick) found = 1;
      end
      total++;
      if (found) passed++;
      else $display("FAIL %s: got no tick expected tick within 300 cycles", nm);
      tick_e = ecnt;
   endtask

   initial begin
      int waits;
      int acc_e;
      int t0;

      total = 0; passed = 0;
      rst = 1'b1; in_data = '0; in_valid = 1'b0;
      gain_shift = '0; mute = 1'b0; clr_status = 1'b0;

      vecs[0]  = '{3'd0, 1'b0, 16'h1234, 8'h12};
      vecs[1]  = '{3'd7, 1'b0, 16'h1234, 8'h7F};
      vecs[2]  = '{3'd7, 1'b0, 16'hFC18, 8'h80};
      vecs[3]  = '{3'd0, 1'b0, 16'hFED4, 8'hFE};
      vecs[4]  = '{3'd4, 1'b0, 16'h0150, 8'h15};
      vecs[5]  = '{3'd1, 1'b0, 16'h7FFF, 8'h7F};
      vecs[6]  = '{3'd1, 1'b0, 16'h8000, 8'h80};
      vecs[7]  = '{3'd3, 1'b0, 16'hFFE0, 8'hFF};
      vecs[8]  = '{3'd2, 1'b0, 16'h1F80, 8'h7E};
      vecs[9]  = '{3'd2, 1'b0, 16'h2000, 8'h7F};
      vecs[10] = '{3'd5, 1'b1, 16'h1234, 8'h00};
      vecs[11] = '{3'd6, 1'b0, 16'hFF00, 8'hC0};
      vecs[12] = '{3'd4, 1'b0, 16'h07F0, 8'h7F};
      vecs[13] = '{3'd4, 1'b0, 16'hF800, 8'h80};
      vecs[14] = '{3'd4, 1'b0, 16'hF7F0, 8'h80};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_tick", int'(frame_tick), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_underrun", int'(underrun_cnt), 0);

      // first frame
      rst = 1'b0;
      #1;
      chk("ready_after_release", int'(in_ready), 1);
      in_data = 16'h1234; in_valid = 1'b1; gain_shift = 3'd0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("level_after_push", int'(fifo_level), 1);
      for (int i = 0; i < 300 && ecnt != 255; i++) @(negedge clk);
      chk("edge255_reached", ecnt, 255);
      chk("pre_tick_data", int'(data_out), 0);
      chk("pre_tick_tick", int'(frame_tick), 0);
      @(negedge clk);
      chk("first_tick", int'(frame_tick), 1);
      chk("first_tick_edge", ecnt, 256);
      chk("first_data", int'(data_out), 8'h12);
      last_e = ecnt;

      // table-driven gain/saturation/mute vectors, one per frame
      for (int v = 0; v < 15; v++) begin
         gain_shift = vecs[v].g; mute = vecs[v].m;
         in_data = vecs[v].d; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         wait_tick($sformatf("vec%0d_tick", v));
         chk($sformatf("vec%0d_spacing", v), tick_e - last_e, 256);
         chk($sformatf("vec%0d_data", v), int'(data_out), int'(vecs[v].e));
         chk($sformatf("vec%0d_level", v), int'(fifo_level), 0);
         last_e = tick_e;
      end
      mute = 1'b0; gain_shift = 3'd0;

      // underrun: three empty slots hold 0x80
      chk("underrun_pre", int'(underrun_cnt), 0);
      for (int k = 1; k <= 3; k++) begin
         wait_tick($sformatf("ur%0d_tick", k));
         chk($sformatf("ur%0d_spacing", k), tick_e - last_e, 256);
         chk($sformatf("ur%0d_hold", k), int'(data_out), 8'h80);
         chk($sformatf("ur%0d_cnt", k), int'(underrun_cnt), k);
         last_e = tick_e;
      end

      // clear held across a 4th underrun: clear wins
      clr_status = 1'b1;
      wait_tick("clr_tick");
      chk("clr_underrun", int'(underrun_cnt), 0);
      chk("clr_hold", int'(data_out), 8'h80);
      last_e = tick_e;
      clr_status = 1'b0;

      // mute during underrun
      mute = 1'b1;
      wait_tick("mute_ur_tick");
      chk("mute_ur_data", int'(data_out), 0);
      chk("mute_ur_cnt", int'(underrun_cnt), 1);
      last_e = tick_e;
      mute = 1'b0;

      // mute with samples queued
      in_valid = 1'b1; in_data = 16'h1234;
      @(negedge clk);
      in_data = 16'h2345;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mute_q_level", int'(fifo_level), 2);
      mute = 1'b1;
      wait_tick("mute_q_tick");
      chk("mute_q_data", int'(data_out), 0);
      chk("mute_q_level_after", int'(fifo_level), 1);
      mute = 1'b0;
      wait_tick("unmute_tick");
      chk("unmute_data", int'(data_out), 8'h23);
      chk("unmute_level", int'(fifo_level), 0);
      t0 = tick_e;

      // backpressure: 17 back-to-back pushes into a 16-deep FIFO
      acc_e = 0;
      for (int i = 0; i < 17; i++) begin
         in_data = 16'((i + 1) << 8);
         in_valid = 1'b1;
         waits = 0;
         while (!in_ready && waits < 400) begin
            @(negedge clk);
            waits++;
         end
         if (i == 16) chk("bp_17th_waited", int'(waits > 0), 1);
         @(posedge clk);
         #1;
         acc_e = ecnt;
         if (i == 15) begin
            chk("bp_peak_level", int'(fifo_level), 16);
            chk("bp_ready_low", int'(in_ready), 0);
         end
      end
      in_valid = 1'b0;
      chk("bp_17th_accept_edge", acc_e - t0, 257);
      chk("bp_level_after", int'(fifo_level), 16);
      chk("bp_first_out", int'(data_out), 1);

      // reset mid-frame with samples queued
      for (int i = 0; i < 300 && (ecnt % 256) != 100; i++) @(negedge clk);
      chk("mid_fcnt100", ecnt % 256, 100);
      chk("mid_pre_underrun", int'(underrun_cnt), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_data", int'(data_out), 0);
      chk("mid_rst_level", int'(fifo_level), 0);
      chk("mid_rst_ready", int'(in_ready), 0);
      chk("mid_rst_underrun", int'(underrun_cnt), 0);
      chk("mid_rst_tick", int'(frame_tick), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_tick("post_rst_tick");
      chk("post_rst_edge", tick_e, 256);
      chk("post_rst_data", int'(data_out), 0);
      chk("post_rst_underrun", int'(underrun_cnt), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
